cpu_sequencer: RTL and testbench

Multi-cycle control state machine for the 10-bit CPU datapath. It replaces the free-running 16-phase counter with explicit states and an instruction-fetch handshake. It drives the fetch controls (IRload, PCload, Jmux) toward MemoryPart, and the register-file, ALU and I/O enables toward CalPart. It also decodes each instruction once and holds it stable for the whole instruction.

---
 rtl/cpu_sequencer.sv | 272 +++++++++++++++++++++++++++
 tb/tb_cpu_sequencer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// Multi-cycle control FSM for the 10-bit CPU datapath: fetch handshake, one-time decode, strobes.
// Optional SINGLE_STEP_EN adds a Step input and a PAUSE state between instructions.
//
// state   | meaning
// IDLE    | waiting for Run
// FETCH   | IRload pulse toward MemoryPart
// WAIT_IR | waiting for IRValid, bounded by IR_TIMEOUT
// DECODE  | iq decoded, Q sampled for conditional jumps
// READ    | register read strobes
// EXEC    | ALU_CYCLES quiet cycles
// WRITE   | write/flag/output strobes and PCload
// PAUSE   | single-step hold (SINGLE_STEP_EN only)
// HALT    | sticky after a zero instruction
// FAULT   | sticky after fetch timeout
module cpu_sequencer #(
    parameter int INSTRUCTION_LEN = 10,
    parameter int ALU_CYCLES      = 2,
    parameter int IR_TIMEOUT      = 15
) (
    input  logic                       Clock,
    input  logic                       Reset,
    input  logic                       Run,
    input  logic [INSTRUCTION_LEN-1:0] IR,
    input  logic                       IRValid,
    input  logic                       Q,
`ifdef SINGLE_STEP_EN
    input  logic                       Step,
`endif
    output logic                       IRload,
    output logic                       PCload,
    output logic                       Jmux,
    output logic                       RAE,
    output logic                       RBE,
    output logic [1:0]                 RAA,
    output logic [1:0]                 RBA,
    output logic [1:0]                 WA,
    output logic                       WE,
    output logic                       IE,
    output logic                       OE,
    output logic                       ZE,
    output logic [2:0]                 OP,
    output logic                       Busy,
    output logic                       Halted,
    output logic                       Fault
);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_WAIT_IR, S_DECODE, S_READ, S_EXEC, S_WRITE, S_HALT, S_FAULT
`ifdef SINGLE_STEP_EN
        , S_PAUSE
`endif
    } state_t;

    typedef struct packed {
        logic       rae;
        logic       rbe;
        logic       we;
        logic       ze;
        logic       oe;
        logic       ie;
        logic       jmux;
        logic [1:0] raa;
        logic [1:0] rba;
        logic [1:0] wa;
        logic [2:0] op;
    } fld_t;

    localparam logic [7:0] EXEC_LAST = 8'(ALU_CYCLES - 1);
    localparam logic [7:0] WAIT_LAST = 8'(IR_TIMEOUT - 1);

    state_t                     state_q, state_d;
    logic [7:0]                 cnt_q, cnt_d;
    logic [INSTRUCTION_LEN-1:0] iq_q, iq_d;
    fld_t                       fld_q, fld_d, dec;
    logic                       in_instr;

    logic       irload_q, irload_d, pcload_q, pcload_d, jmux_q, jmux_d;
    logic       rae_q, rae_d, rbe_q, rbe_d, we_q, we_d, ie_q, ie_d;
    logic       oe_q, oe_d, ze_q, ze_d, busy_q, busy_d, halted_q, halted_d;
    logic       fault_q, fault_d;
    logic [1:0] raa_q, raa_d, rba_q, rba_d, wa_q, wa_d;
    logic [2:0] op_q, op_d;

    // state register plus registered outputs; reset clears every strobe at once
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            iq_q     <= '0;
            fld_q    <= '0;
            irload_q <= 1'b0;
            pcload_q <= 1'b0;
            jmux_q   <= 1'b1;
            rae_q    <= 1'b0;
            rbe_q    <= 1'b0;
            raa_q    <= '0;
            rba_q    <= '0;
            wa_q     <= '0;
            we_q     <= 1'b0;
            ie_q     <= 1'b0;
            oe_q     <= 1'b0;
            ze_q     <= 1'b0;
            op_q     <= '0;
            busy_q   <= 1'b0;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            iq_q     <= iq_d;
            fld_q    <= fld_d;
            irload_q <= irload_d;
            pcload_q <= pcload_d;
            jmux_q   <= jmux_d;
            rae_q    <= rae_d;
            rbe_q    <= rbe_d;
            raa_q    <= raa_d;
            rba_q    <= rba_d;
            wa_q     <= wa_d;
            we_q     <= we_d;
            ie_q     <= ie_d;
            oe_q     <= oe_d;
            ze_q     <= ze_d;
            op_q     <= op_d;
            busy_q   <= busy_d;
            halted_q <= halted_d;
            fault_q  <= fault_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        iq_d    = iq_q;
        case (state_q)
            S_IDLE:    if (Run) state_d = S_FETCH;
            S_FETCH: begin
                state_d = S_WAIT_IR;
                cnt_d   = '0;
            end
            S_WAIT_IR: begin
                if (IRValid) begin
                    iq_d    = IR;
                    state_d = S_DECODE;
                end else if (cnt_q == WAIT_LAST) begin
                    state_d = S_FAULT;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_DECODE:  state_d = (iq_q == '0) ? S_HALT : S_READ;
            S_READ: begin
                state_d = S_EXEC;
                cnt_d   = EXEC_LAST;
            end
            S_EXEC: begin
                if (cnt_q == 8'd0) state_d = S_WRITE;
                else               cnt_d   = cnt_q - 8'd1;
            end
`ifdef SINGLE_STEP_EN
            S_WRITE:   state_d = Run ? S_PAUSE : S_IDLE;
            S_PAUSE: begin
                if (!Run)      state_d = S_IDLE;
                else if (Step) state_d = S_FETCH;
            end
`else
            S_WRITE:   state_d = Run ? S_FETCH : S_IDLE;
`endif
            S_HALT:    state_d = S_HALT;
            S_FAULT:   state_d = S_FAULT;
            default:   state_d = S_IDLE;
        endcase
    end

    // instruction decode; unlisted classes leave every strobe off and Jmux at PC+1
    always_comb begin
        dec      = '0;
        dec.jmux = 1'b1;
        dec.op   = iq_q[8:6];
        if (iq_q[9]) begin
            dec.wa = iq_q[8:7];
            dec.ie = 1'b1;
            dec.we = 1'b1;
        end else if (iq_q[8]) begin
            dec.raa = iq_q[3:2];
            dec.rba = iq_q[1:0];
            dec.rae = 1'b1;
            dec.rbe = 1'b1;
            dec.wa  = iq_q[5:4];
            dec.we  = 1'b1;
            dec.ze  = 1'b1;
        end else if (iq_q[7]) begin
            dec.raa = iq_q[5:4];
            dec.rae = 1'b1;
            dec.wa  = iq_q[5:4];
            dec.we  = 1'b1;
            dec.ze  = 1'b1;
        end else begin
            case (iq_q[6:4])
                3'b111: begin
                    dec.raa = iq_q[3:2];
                    dec.rba = iq_q[1:0];
                    dec.rae = 1'b1;
                    dec.rbe = 1'b1;
                    dec.ze  = 1'b1;
                end
                3'b001, 3'b011: begin
                    dec.raa = iq_q[1:0];
                    dec.rae = 1'b1;
                    dec.wa  = iq_q[3:2];
                    dec.we  = 1'b1;
                    dec.ze  = iq_q[5];
                end
                3'b010: begin
                    if (iq_q[3:2] == 2'b00) begin
                        dec.wa = iq_q[1:0];
                        dec.ie = 1'b1;
                        dec.we = 1'b1;
                    end else if (iq_q[3:2] == 2'b01) begin
                        dec.raa = iq_q[1:0];
                        dec.rae = 1'b1;
                        dec.oe  = 1'b1;
                    end
                end
                3'b100:  dec.jmux = 1'b0;
                3'b101:  dec.jmux = Q;
                3'b110:  dec.jmux = ~Q;
                default: dec.jmux = 1'b1;
            endcase
        end
    end

    // outputs are computed from the next state so every port comes straight off a flop
    always_comb begin
        fld_d    = (state_q == S_DECODE) ? dec : fld_q;
        in_instr = (state_d == S_READ) || (state_d == S_EXEC) || (state_d == S_WRITE);
        irload_d = (state_d == S_FETCH);
        pcload_d = (state_d == S_WRITE);
        rae_d    = (state_d == S_READ) & fld_d.rae;
        rbe_d    = (state_d == S_READ) & fld_d.rbe;
        we_d     = (state_d == S_WRITE) & fld_d.we;
        ze_d     = (state_d == S_WRITE) & fld_d.ze;
        oe_d     = (state_d == S_WRITE) & fld_d.oe;
        ie_d     = in_instr & fld_d.ie;
        jmux_d   = in_instr ? fld_d.jmux : 1'b1;
        raa_d    = fld_d.raa;
        rba_d    = fld_d.rba;
        wa_d     = fld_d.wa;
        op_d     = fld_d.op;
        busy_d   = !((state_d == S_IDLE) || (state_d == S_HALT) || (state_d == S_FAULT));
        halted_d = (state_d == S_HALT);
        fault_d  = (state_d == S_FAULT);
    end

    assign IRload = irload_q;
    assign PCload = pcload_q;
    assign Jmux   = jmux_q;
    assign RAE    = rae_q;
    assign RBE    = rbe_q;
    assign RAA    = raa_q;
    assign RBA    = rba_q;
    assign WA     = wa_q;
    assign WE     = we_q;
    assign IE     = ie_q;
    assign OE     = oe_q;
    assign ZE     = ze_q;
    assign OP     = op_q;
    assign Busy   = busy_q;
    assign Halted = halted_q;
    assign Fault  = fault_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: directed plan cases plus random instructions
// checked cycle by cycle against an instruction-level timeline model.
module tb_cpu_sequencer;
    localparam int A = 2;
    localparam int T = 15;

    logic       Clock = 1'b0;
    logic       Reset, Run, IRValid, Q;
    logic [9:0] IR;
`ifdef SINGLE_STEP_EN
    logic       Step;
`endif
    logic       IRload, PCload, Jmux, RAE, RBE, WE, IE, OE, ZE, Busy, Halted, Fault;
    logic [1:0] RAA, RBA, WA;
    logic [2:0] OP;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 Clock = ~Clock;

    cpu_sequencer #(.INSTRUCTION_LEN(10), .ALU_CYCLES(A), .IR_TIMEOUT(T)) dut (
        .Clock(Clock), .Reset(Reset), .Run(Run), .IR(IR), .IRValid(IRValid), .Q(Q),
`ifdef SINGLE_STEP_EN
        .Step(Step),
`endif
        .IRload(IRload), .PCload(PCload), .Jmux(Jmux), .RAE(RAE), .RBE(RBE),
        .RAA(RAA), .RBA(RBA), .WA(WA), .WE(WE), .IE(IE), .OE(OE), .ZE(ZE),
        .OP(OP), .Busy(Busy), .Halted(Halted), .Fault(Fault)
    );

    typedef struct packed {
        bit       rae, rbe, we, ze, oe, ie, jmux;
        bit [1:0] raa, rba, wa;
        bit [2:0] op;
    } exp_t;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input bit [9:0] w, input bit q);
        exp_t e;
        e      = '0;
        e.jmux = 1'b1;
        e.op   = w[8:6];
        casez (w)
            10'b1?_????_????: begin e.wa = w[8:7]; e.ie = 1; e.we = 1; end
            10'b01_????_????: begin
                e.raa = w[3:2]; e.rba = w[1:0]; e.rae = 1; e.rbe = 1;
                e.wa = w[5:4]; e.we = 1; e.ze = 1;
            end
            10'b00_1???_????: begin e.raa = w[5:4]; e.rae = 1; e.wa = w[5:4]; e.we = 1; e.ze = 1; end
            10'b00_0111_????: begin e.raa = w[3:2]; e.rba = w[1:0]; e.rae = 1; e.rbe = 1; e.ze = 1; end
            10'b00_0001_????: begin e.raa = w[1:0]; e.rae = 1; e.wa = w[3:2]; e.we = 1; end
            10'b00_0011_????: begin e.raa = w[1:0]; e.rae = 1; e.wa = w[3:2]; e.we = 1; e.ze = 1; end
            10'b00_0010_00??: begin e.wa = w[1:0]; e.ie = 1; e.we = 1; end
            10'b00_0010_01??: begin e.raa = w[1:0]; e.rae = 1; e.oe = 1; end
            10'b00_0100_????: e.jmux = 0;
            10'b00_0101_????: e.jmux = q;
            10'b00_0110_????: e.jmux = !q;
            default: ;
        endcase
        return e;
    endfunction

    task automatic chk_reset_vals(input string p);
        chk({p, "_IRload"}, IRload, 0); chk({p, "_PCload"}, PCload, 0);
        chk({p, "_RAE"}, RAE, 0);       chk({p, "_RBE"}, RBE, 0);
        chk({p, "_WE"}, WE, 0);         chk({p, "_ZE"}, ZE, 0);
        chk({p, "_OE"}, OE, 0);         chk({p, "_IE"}, IE, 0);
        chk({p, "_Jmux"}, Jmux, 1);     chk({p, "_Busy"}, Busy, 0);
        chk({p, "_Halted"}, Halted, 0); chk({p, "_Fault"}, Fault, 0);
        chk({p, "_OP"}, OP, 0);         chk({p, "_RAA"}, RAA, 0);
        chk({p, "_RBA"}, RBA, 0);       chk({p, "_WA"}, WA, 0);
    endtask

    // Called at the negedge of a FETCH cycle. d = WAIT_IR cycles before IRValid.
    // abort_cyc > 0 applies Reset asynchronously during that cycle of the instruction.
    task automatic run_instr(input bit [9:0] ir, input int d, input bit qv,
                             input bit run_after, input int abort_cyc);
        exp_t e;
        int   last;
        e    = model(ir, qv);
        last = 5 + d + A;
        for (int c = 1; c <= last; c++) begin
            bit f, wr, rd, in_i;
            f    = (c == 1);
            wr   = (c == last);
            rd   = (c == 4 + d);
            in_i = (c >= 4 + d);
            chk("IRload", IRload, f);
            chk("PCload", PCload, wr);
            chk("RAE", RAE, rd & e.rae);
            chk("RBE", RBE, rd & e.rbe);
            chk("WE", WE, wr & e.we);
            chk("ZE", ZE, wr & e.ze);
            chk("OE", OE, wr & e.oe);
            chk("IE", IE, in_i & e.ie);
            chk("Jmux", Jmux, in_i ? e.jmux : 1'b1);
            chk("Busy", Busy, 1);
            chk("Halted", Halted, 0);
            chk("Fault", Fault, 0);
            if (in_i) begin
                chk("OP", OP, e.op);
                if (e.rae) chk("RAA", RAA, e.raa);
                if (e.rbe) chk("RBA", RBA, e.rba);
            end
            if (wr && e.we) chk("WA", WA, e.wa);
            if (c == abort_cyc) begin
                #2 Reset = 1'b1;
                #1 chk_reset_vals("abort");
                @(negedge Clock);
                Run = 1'b0; IRValid = 1'b0;
                Reset = 1'b0;
                repeat (8) begin
                    @(negedge Clock);
                    chk("post_abort_WE", WE, 0);
                    chk("post_abort_PCload", PCload, 0);
                    chk("post_abort_Busy", Busy, 0);
                    chk("post_abort_IRload", IRload, 0);
                end
                return;
            end
            if (f)            IRValid = 1'b1;
            else if (c < 2 + d) IRValid = 1'b0;
            else if (c == 2 + d) IRValid = 1'b1;
            else              IRValid = 1'($urandom_range(0, 1));
            IR  = (c == 2 + d) ? ir : 10'($urandom);
            Q   = (c == 3 + d) ? qv : !qv;
            Run = wr ? run_after : 1'($urandom_range(0, 1));
            @(negedge Clock);
        end
        if (!run_after) begin
            chk("end_idle_Busy", Busy, 0);
            chk("end_idle_IRload", IRload, 0);
        end else begin
`ifdef SINGLE_STEP_EN
            chk("pause_Busy", Busy, 1);
            chk("pause_IRload", IRload, 0);
            chk("pause_PCload", PCload, 0);
            if (Step) @(negedge Clock);
`else
            chk("next_IRload", IRload, 1);
`endif
        end
    endtask

    task automatic do_reset(input string p);
        Reset = 1'b1;
        #1 chk_reset_vals(p);
        @(negedge Clock);
        Reset = 1'b0; Run = 1'b0; IRValid = 1'b0;
        @(negedge Clock);
        chk({p, "_idle_Busy"}, Busy, 0);
    endtask

    initial begin
        bit [9:0] r_ir;
        int       r_d;
        bit       r_run;

        Reset = 1'b1; Run = 1'b0; IRValid = 1'b0; IR = '0; Q = 1'b0;
`ifdef SINGLE_STEP_EN
        Step = 1'b1;
`endif
        repeat (2) @(negedge Clock);
        chk_reset_vals("reset");
        Reset = 1'b0;
        repeat (2) @(negedge Clock);
        chk("idle_Busy", Busy, 0);
        chk("idle_IRload", IRload, 0);

        Run = 1'b1;
        @(negedge Clock);
        run_instr(10'b10_0110_0000, 0, 0, 1, 0);
        run_instr(10'b01_0101_1011, 0, 0, 1, 0);
        run_instr(10'b00_0111_0110, 1, 0, 1, 0);
        run_instr(10'b00_0101_0000, 0, 1, 1, 0);
        run_instr(10'b00_0101_0000, 2, 0, 1, 0);
        run_instr(10'b00_0110_0000, 0, 0, 1, 0);
        run_instr(10'b00_0100_0011, 0, 1, 1, 0);
        run_instr(10'b00_0010_0010, 0, 0, 1, 0);
        run_instr(10'b00_0010_0111, 0, 0, 1, 0);
        run_instr(10'b00_1011_0000, T - 1, 0, 1, 0);
        run_instr(10'b00_0011_1101, 3, 1, 0, 0);
        Run = 1'b1;
        @(negedge Clock);

        for (int i = 0; i < 40; i++) begin
            r_ir = 10'($urandom);
            if (r_ir == '0) r_ir = 10'd1;
            r_d   = ($urandom_range(0, 7) == 0) ? T - 1 : int'($urandom_range(0, 3));
            r_run = ($urandom_range(0, 3) != 0);
            run_instr(r_ir, r_d, 1'($urandom_range(0, 1)), r_run, 0);
            if (!r_run) begin
                Run = 1'b1;
                @(negedge Clock);
            end
        end

        // reset during the first EXEC cycle of an ALU instruction
        run_instr(10'b01_0101_1011, 0, 0, 1, 5);

        Run = 1'b1;
        @(negedge Clock);
        chk("halt_fetch_IRload", IRload, 1);
        IRValid = 1'b0;
        @(negedge Clock);
        IR = '0; IRValid = 1'b1;
        @(negedge Clock);
        chk("halt_decode_Halted", Halted, 0);
        IRValid = 1'b0;
        @(negedge Clock);
        repeat (6) begin
            chk("halt_Halted", Halted, 1);
            chk("halt_Busy", Busy, 0);
            chk("halt_PCload", PCload, 0);
            chk("halt_IRload", IRload, 0);
            chk("halt_WE", WE, 0);
            IRValid = 1'($urandom_range(0, 1));
            IR      = 10'($urandom);
            @(negedge Clock);
        end
        do_reset("halt_rst");

        Run = 1'b1;
        @(negedge Clock);
        chk("to_fetch_IRload", IRload, 1);
        IRValid = 1'b0;
        @(negedge Clock);
        for (int w = 1; w <= T; w++) begin
            chk("to_wait_Busy", Busy, 1);
            chk("to_wait_Fault", Fault, 0);
            chk("to_wait_IRload", IRload, 0);
            @(negedge Clock);
        end
        repeat (5) begin
            chk("to_Fault", Fault, 1);
            chk("to_Busy", Busy, 0);
            chk("to_IRload", IRload, 0);
            IRValid = 1'b1;
            Run     = 1'($urandom_range(0, 1));
            @(negedge Clock);
        end
        do_reset("fault_rst");

`ifdef SINGLE_STEP_EN
        Run = 1'b1;
        @(negedge Clock);
        Step = 1'b0;
        run_instr(10'b01_0101_1011, 0, 0, 1, 0);
        repeat (5) begin
            chk("step_hold_Busy", Busy, 1);
            chk("step_hold_IRload", IRload, 0);
            chk("step_hold_WE", WE, 0);
            @(negedge Clock);
        end
        Step = 1'b1;
        @(negedge Clock);
        Step = 1'b0;
        run_instr(10'b10_0110_0000, 0, 0, 1, 0);
        repeat (3) begin
            chk("step_end_Busy", Busy, 1);
            chk("step_end_WE", WE, 0);
            chk("step_end_PCload", PCload, 0);
            @(negedge Clock);
        end
        Run = 1'b0;
        @(negedge Clock);
        chk("step_idle_Busy", Busy, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
